// File: rtl/channel_merge_arb.sv
// N-way valid/ack channel merge with route-field prefix, round-robin or fixed-priority
// arbitration with aging, and a single registered output stage.
module channel_merge_arb #(
    parameter int unsigned                  NIN      = 4,
    parameter int unsigned                  NDATA    = 27,
    parameter int unsigned                  NROUTE   = 8,
    parameter logic [NIN-1:0][NROUTE-1:0]   ROUTES   = '0,
    parameter int unsigned                  MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [NIN*NDATA-1:0]    in_d,
    input  logic [NIN-1:0]          in_v,
    output logic [NIN-1:0]          in_a,
    output logic [NROUTE+NDATA-1:0] out_d,
    output logic                    out_v,
    input  logic                    out_a,
    output logic [NIN-1:0]          starved
);

    localparam int unsigned PW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [PW-1:0] PTR_LAST = PW'(NIN - 1);

    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]             cnt_q [NIN];
    logic [CW-1:0]             cnt_d [NIN];
    logic [NIN-1:0]            starved_q, starved_d;
    logic [NROUTE+NDATA-1:0]   out_d_q, out_d_d;
    logic                      out_v_q, out_v_d;

    logic [NIN-1:0]            grant;
    logic [PW-1:0]             gidx;
    logic                      found;
    logic                      load_en;
    logic                      xfer;
    logic [NDATA-1:0]          sel_data;
    logic [NROUTE-1:0]         sel_route;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        if (mode) begin
            // Inputs that have aged out pre-empt the plain priority order.
            if (MAX_WAIT != 0) begin
                for (int unsigned i = 0; i < NIN; i++) begin
                    if (!found && in_v[i] && cnt_q[i] == WAIT_MAX) begin
                        found = 1'b1;
                        gidx  = PW'(i);
                    end
                end
            end
            for (int unsigned i = 0; i < NIN; i++) begin
                if (!found && in_v[i]) begin
                    found = 1'b1;
                    gidx  = PW'(i);
                end
            end
        end else begin
            for (int unsigned off = 1; off <= NIN; off++) begin
                if (!found && in_v[(32'(rr_ptr_q) + off) % NIN]) begin
                    found = 1'b1;
                    gidx  = PW'((32'(rr_ptr_q) + off) % NIN);
                end
            end
        end
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    assign load_en = (~out_v_q | out_a) & reset;
    assign in_a    = grant & {NIN{load_en}};
    assign xfer    = found & load_en;

    always_comb begin
        sel_data  = '0;
        sel_route = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (grant[i]) begin
                sel_data  = in_d[i*NDATA +: NDATA];
                sel_route = ROUTES[i];
            end
        end
    end

    always_comb begin
        out_d_d  = out_d_q;
        out_v_d  = out_v_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            out_d_d = {sel_route, sel_data};
            out_v_d = 1'b1;
            if (!mode) rr_ptr_d = gidx;
        end else if (out_a) begin
            out_v_d = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NIN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!in_v[i] || in_a[i]) begin
                cnt_d[i] = '0;
            end else if (xfer && cnt_q[i] != WAIT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            starved_d[i] = (MAX_WAIT != 0) && (cnt_d[i] == WAIT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= PTR_LAST;
            out_d_q   <= '0;
            out_v_q   <= 1'b0;
            starved_q <= '0;
            for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            out_d_q   <= out_d_d;
            out_v_q   <= out_v_d;
            starved_q <= starved_d;
            for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign out_d   = out_d_q;
    assign out_v   = out_v_q;
    assign starved = starved_q;

endmodule

// File: tb/tb_channel_merge_arb.sv
// Directed-vector bench for channel_merge_arb: NIN=4, NDATA=27, NROUTE=8, MAX_WAIT=3.
module tb_channel_merge_arb;

    localparam logic [7:0] RT [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [107:0]  in_d;
    logic [3:0]    in_v;
    logic [3:0]    in_a;
    logic [34:0]   out_d;
    logic          out_v;
    logic          out_a;
    logic [3:0]    starved;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [22:0]   seq [4];
    logic [34:0]   exp_q [$];
    logic [34:0]   w, hold;
    logic [3:0]    acc;

    channel_merge_arb #(
        .NIN      (4),
        .NDATA    (27),
        .NROUTE   (8),
        .ROUTES   ({8'hD4, 8'hC3, 8'hB2, 8'hA1}),
        .MAX_WAIT (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .in_d    (in_d),
        .in_v    (in_v),
        .in_a    (in_a),
        .out_d   (out_d),
        .out_v   (out_v),
        .out_a   (out_a),
        .starved (starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_d();
        for (int unsigned i = 0; i < 4; i++) in_d[i*27 +: 27] = {4'(i), seq[i]};
    endtask

    function automatic logic [34:0] exp_word(input int unsigned e);
        return {RT[e], 4'(e), seq[e]};
    endfunction

    // Source model: a word is consumed when valid and ack are both high at the edge.
    task automatic cycle();
        logic [3:0] a;
        a = in_v & in_a;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < 4; i++) if (a[i]) seq[i] = seq[i] + 1'b1;
        drive_d();
    endtask

    initial begin
        for (int unsigned i = 0; i < 4; i++) seq[i] = 23'(i * 100);
        drive_d();
        reset = 1'b0;
        mode  = 1'b0;
        in_v  = 4'hF;
        out_a = 1'b1;
        #1;
        chk("rst_in_a", in_a, 0);
        repeat (3) cycle();
        chk("rst_out_v", out_v, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_in_a_held", in_a, 0);
        chk("rst_starved", starved, 0);

        reset = 1'b1;
        #1;
        chk("first_grant", in_a, 4'b0001);

        for (int unsigned k = 0; k < 8; k++) begin
            chk("rr_grant", in_a, 64'(1 << (k % 4)));
            w = exp_word(k % 4);
            cycle();
            chk("rr_out_v", out_v, 1);
            chk("rr_out_d", out_d, w);
            chk("rr_starved", starved, (k >= 2) ? 64'(1 << ((k + 1) % 4)) : 64'd0);
        end

        hold  = w;
        out_a = 1'b0;
        #1;
        chk("bp_in_a", in_a, 0);
        for (int unsigned k = 0; k < 5; k++) begin
            cycle();
            chk("bp_out_d", out_d, hold);
            chk("bp_out_v", out_v, 1);
            chk("bp_in_a", in_a, 0);
            chk("bp_starved", starved, 4'b0001);
        end
        out_a = 1'b1;
        #1;
        chk("bp_release_grant", in_a, 4'b0001);
        w = exp_word(0);
        cycle();
        chk("bp_next_out_d", out_d, w);
        chk("bp_next_starved", starved, 4'b0010);

        reset = 1'b0;
        #1;
        chk("midrst_out_v", out_v, 0);
        chk("midrst_out_d", out_d, 0);
        chk("midrst_in_a", in_a, 0);
        chk("midrst_starved", starved, 0);
        cycle();
        mode  = 1'b1;
        in_v  = 4'b0011;
        reset = 1'b1;
        #1;

        for (int unsigned j = 0; j < 8; j++) begin
            chk("prio_grant", in_a, ((j % 4) == 3) ? 64'd2 : 64'd1);
            w = exp_word(((j % 4) == 3) ? 1 : 0);
            cycle();
            chk("prio_out_d", out_d, w);
            chk("prio_starved", starved, ((j % 4) == 2) ? 64'd2 : 64'd0);
        end

        in_v = 4'hF;
        for (int unsigned c = 0; c < 24; c++) begin
            if ((c % 3) == 0) mode = ~mode;
            #1;
            chk("ms_onehot", 64'($onehot(in_a)), 1);
            acc = in_v & in_a;
            for (int unsigned i = 0; i < 4; i++) if (acc[i]) exp_q.push_back(exp_word(i));
            cycle();
            chk("ms_out_v", out_v, 1);
            if (exp_q.size() != 0) chk("ms_out_d", out_d, exp_q.pop_front());
            else chk("ms_no_accept", acc, 4'b1111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
